// File: rtl/board_io_irq_ctrl.sv
// Board I/O front end: switch/button synchronisers, button debounce, latched
// press interrupts with mask, LED register and a clock-enable tick generator.
module board_io_irq_ctrl #(
    parameter int BTN_COUNT       = 6,
    parameter int SW_WIDTH        = 8,
    parameter int LED_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CLK_DIV         = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [BTN_COUNT-1:0] i_btn_raw,
    input  logic [SW_WIDTH-1:0]  i_sw_raw,
    input  logic [BTN_COUNT-1:0] i_irq_mask,
    input  logic [BTN_COUNT-1:0] i_irq_clear,
    input  logic [LED_WIDTH-1:0] i_led_wdata,
    input  logic                 i_led_we,
    output logic [SW_WIDTH-1:0]  o_sw_sync,
    output logic [BTN_COUNT-1:0] o_btn_state,
    output logic [BTN_COUNT-1:0] o_btn_pending,
    output logic                 o_irq,
    output logic [LED_WIDTH-1:0] o_led,
    output logic                 o_tick
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // A divide-by-1 still needs a 1-bit counter so the compare stays legal.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [BTN_COUNT-1:0] r_btn_meta;
    logic [BTN_COUNT-1:0] r_btn_sync;
    logic [SW_WIDTH-1:0]  r_sw_meta;
    logic [SW_WIDTH-1:0]  r_sw_sync;

    logic [CNT_W-1:0]     r_db_cnt [BTN_COUNT];
    logic [CNT_W-1:0]     w_db_cnt_next [BTN_COUNT];
    logic [BTN_COUNT-1:0] r_btn_state;
    logic [BTN_COUNT-1:0] w_btn_state_next;
    logic [BTN_COUNT-1:0] w_btn_rise;

    logic [BTN_COUNT-1:0] r_pending;
    logic [BTN_COUNT-1:0] w_pending_next;
    logic                 r_irq;
    logic [LED_WIDTH-1:0] r_led;

    logic [DIV_W-1:0]     r_div_cnt;
    logic                 w_div_wrap;
    logic                 r_tick;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_btn_meta <= i_btn_raw;
            r_btn_sync <= r_btn_meta;
            r_sw_meta  <= i_sw_raw;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // Any cycle where the synced level agrees with the accepted level restarts the count.
    always_comb begin
        w_btn_state_next = r_btn_state;
        for (int i = 0; i < BTN_COUNT; i++) begin
            w_db_cnt_next[i] = '0;
            if (r_btn_sync[i] != r_btn_state[i]) begin
                if (r_db_cnt[i] == DB_LAST) begin
                    w_btn_state_next[i] = r_btn_sync[i];
                end else begin
                    w_db_cnt_next[i] = r_db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < BTN_COUNT; i++) begin
                r_db_cnt[i] <= '0;
            end
            r_btn_state <= '0;
        end else begin
            for (int i = 0; i < BTN_COUNT; i++) begin
                r_db_cnt[i] <= w_db_cnt_next[i];
            end
            r_btn_state <= w_btn_state_next;
        end
    end

    // Press detect uses the next state so pending sets on the same edge the level rises.
    assign w_btn_rise     = w_btn_state_next & ~r_btn_state;
    assign w_pending_next = (r_pending & ~i_irq_clear) | w_btn_rise;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pending <= '0;
            r_irq     <= 1'b0;
            r_led     <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_irq     <= |(r_pending & i_irq_mask);
            if (i_led_we) begin
                r_led <= i_led_wdata;
            end
        end
    end

    assign w_div_wrap = (r_div_cnt == DIV_LAST);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
            r_tick    <= w_div_wrap;
        end
    end

    assign o_sw_sync     = r_sw_sync;
    assign o_btn_state   = r_btn_state;
    assign o_btn_pending = r_pending;
    assign o_irq         = r_irq;
    assign o_led         = r_led;
    assign o_tick        = r_tick;

endmodule

// File: tb/tb_board_io_irq_ctrl.sv
// Bench for board_io_irq_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_board_io_irq_ctrl;

    localparam int NB = 6;
    localparam int NS = 8;
    localparam int NL = 8;
    localparam int DB = 4;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw, irq_mask, irq_clear;
    logic [NS-1:0] sw_raw;
    logic [NL-1:0] led_wdata;
    logic          led_we;

    logic [NS-1:0] sw_sync, d1_sw_sync;
    logic [NB-1:0] btn_state, btn_pending, d1_btn_state, d1_btn_pending;
    logic          irq, tick, d1_irq, d1_tick;
    logic [NL-1:0] led, d1_led;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    board_io_irq_ctrl #(.BTN_COUNT(NB), .SW_WIDTH(NS), .LED_WIDTH(NL),
                        .DEBOUNCE_CYCLES(DB), .CLK_DIV(DIV)) dut (
        .i_clock(clk), .i_reset(reset), .i_btn_raw(btn_raw), .i_sw_raw(sw_raw),
        .i_irq_mask(irq_mask), .i_irq_clear(irq_clear), .i_led_wdata(led_wdata),
        .i_led_we(led_we), .o_sw_sync(sw_sync), .o_btn_state(btn_state),
        .o_btn_pending(btn_pending), .o_irq(irq), .o_led(led), .o_tick(tick));

    board_io_irq_ctrl #(.BTN_COUNT(NB), .SW_WIDTH(NS), .LED_WIDTH(NL),
                        .DEBOUNCE_CYCLES(DB), .CLK_DIV(1)) dut1 (
        .i_clock(clk), .i_reset(reset), .i_btn_raw(btn_raw), .i_sw_raw(sw_raw),
        .i_irq_mask(irq_mask), .i_irq_clear(irq_clear), .i_led_wdata(led_wdata),
        .i_led_we(led_we), .o_sw_sync(d1_sw_sync), .o_btn_state(d1_btn_state),
        .o_btn_pending(d1_btn_pending), .o_irq(d1_irq), .o_led(d1_led), .o_tick(d1_tick));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw samples pass through a 2-deep queue; a channel's
    // accepted level flips once the last DB synced samples all disagree with it.
    logic          m_valid = 1'b0;
    logic [NB-1:0] m_state, m_pend, m_next, m_sync_pre;
    logic          m_irq, m_tick, m_tick1, m_all;
    logic [NL-1:0] m_led;
    logic [NS-1:0] m_sw_sync, m_sw_drop;
    logic [NB-1:0] raw_q[$];
    logic [NS-1:0] sw_q[$];
    logic [NB-1:0] sync_q[$];
    logic [NB-1:0] m_drop;
    int            n_since;

    always @(posedge clk) begin
        if (reset) begin
            m_state = '0; m_pend = '0; m_irq = 1'b0; m_led = '0;
            m_sw_sync = '0; m_tick = 1'b0; m_tick1 = 1'b0;
            raw_q.delete(); raw_q.push_back('0); raw_q.push_back('0);
            sw_q.delete();  sw_q.push_back('0);  sw_q.push_back('0);
            sync_q.delete();
            n_since = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_sync_pre = raw_q.pop_front();
            raw_q.push_back(btn_raw);
            m_sw_sync = sw_q[1];
            m_sw_drop = sw_q.pop_front();
            sw_q.push_back(sw_raw);
            sync_q.push_back(m_sync_pre);
            if (sync_q.size() > DB) m_drop = sync_q.pop_front();
            m_next = m_state;
            if (sync_q.size() == DB) begin
                for (int i = 0; i < NB; i++) begin
                    m_all = 1'b1;
                    foreach (sync_q[k]) if (sync_q[k][i] == m_state[i]) m_all = 1'b0;
                    if (m_all) m_next[i] = ~m_state[i];
                end
            end
            m_irq  = |(m_pend & irq_mask);
            m_pend = (m_pend & ~irq_clear) | (m_next & ~m_state);
            m_state = m_next;
            if (led_we) m_led = led_wdata;
            n_since++;
            m_tick  = (n_since % DIV) == 0;
            m_tick1 = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("sw_sync",     32'(sw_sync),        32'(m_sw_sync));
            chk("btn_state",   32'(btn_state),      32'(m_state));
            chk("btn_pending", 32'(btn_pending),    32'(m_pend));
            chk("irq",         32'(irq),            32'(m_irq));
            chk("led",         32'(led),            32'(m_led));
            chk("tick",        32'(tick),           32'(m_tick));
            chk("d1_btn_state",32'(d1_btn_state),   32'(m_state));
            chk("d1_pending",  32'(d1_btn_pending), 32'(m_pend));
            chk("d1_irq",      32'(d1_irq),         32'(m_irq));
            chk("d1_sw_sync",  32'(d1_sw_sync),     32'(m_sw_sync));
            chk("d1_led",      32'(d1_led),         32'(m_led));
            chk("d1_tick",     32'(d1_tick),        32'(m_tick1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int hold [NB];

    initial begin
        reset = 1'b1; btn_raw = '0; sw_raw = '0; irq_mask = '0; irq_clear = '0;
        led_wdata = '0; led_we = 1'b0;
        step(3);
        chk("rst_state", 32'(btn_state), 32'h0);
        chk("rst_pending", 32'(btn_pending), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_sw", 32'(sw_sync), 32'h0);

        // press btn0, mask all
        reset = 1'b0; btn_raw = 6'h01; irq_mask = 6'h3F; sw_raw = 8'h5A;
        step(2); chk("sw_lat2", 32'(sw_sync), 32'h5A); chk("tick_e2", 32'(tick), 32'h0);
        step(2); chk("tick_e4", 32'(tick), 32'h1); chk("tick1_e4", 32'(d1_tick), 32'h1);
        step(1); chk("db_e5", 32'(btn_state), 32'h00); chk("tick_e5", 32'(tick), 32'h0);
        step(1); chk("db_e6", 32'(btn_state), 32'h01);
                 chk("pend_e6", 32'(btn_pending), 32'h01); chk("irq_e6", 32'(irq), 32'h0);
        step(1); chk("irq_e7", 32'(irq), 32'h1);
        step(1); chk("tick_e8", 32'(tick), 32'h1);
        irq_clear = 6'h01; step(1); irq_clear = '0;
        chk("clr_pend", 32'(btn_pending), 32'h0); chk("clr_irq_lag", 32'(irq), 32'h1);
        step(1); chk("clr_irq", 32'(irq), 32'h0);

        // glitch shorter than debounce window
        btn_raw = 6'h05; step(3); btn_raw = 6'h01; step(10);
        chk("glitch_state", 32'(btn_state), 32'h01);
        chk("glitch_pend", 32'(btn_pending), 32'h00);
        chk("glitch_irq", 32'(irq), 32'h0);

        // masked press, then unmask, then clear
        irq_mask = '0; btn_raw = 6'h03; step(8);
        chk("mask_pend", 32'(btn_pending), 32'h02); chk("mask_irq", 32'(irq), 32'h0);
        irq_mask = 6'h02; step(1); chk("unmask_irq", 32'(irq), 32'h1);
        irq_clear = 6'h02; step(1); irq_clear = '0;
        chk("clr2_pend", 32'(btn_pending), 32'h0);
        step(1); chk("clr2_irq", 32'(irq), 32'h0);

        // clear coinciding with rise: set wins
        btn_raw = 6'h0B; step(5); irq_clear = 6'h08; step(1); irq_clear = '0;
        chk("simul_state", 32'(btn_state), 32'h0B);
        chk("simul_pend", 32'(btn_pending), 32'h08);
        irq_clear = 6'h08; step(1); irq_clear = '0;
        btn_raw = '0; step(8);
        chk("rel_state", 32'(btn_state), 32'h00);
        chk("rel_pend", 32'(btn_pending), 32'h00);

        // reset mid-operation
        led_wdata = 8'hA5; led_we = 1'b1; step(1); led_we = 1'b0;
        chk("led_wr", 32'(led), 32'hA5);
        btn_raw = 6'h01; step(7); chk("pre_rst_pend", 32'(btn_pending), 32'h01);
        btn_raw = 6'h11; step(4);
        reset = 1'b1; step(1); reset = 1'b0;
        chk("mid_rst_state", 32'(btn_state), 32'h0);
        chk("mid_rst_pend", 32'(btn_pending), 32'h0);
        chk("mid_rst_led", 32'(led), 32'h0);
        chk("mid_rst_sw", 32'(sw_sync), 32'h0);
        chk("mid_rst_tick", 32'(tick), 32'h0);
        step(5); chk("redb_e5", 32'(btn_state), 32'h00);
        step(1); chk("redb_e6", 32'(btn_state), 32'h11);
        chk("redb_pend", 32'(btn_pending), 32'h11);

        // randomized traffic
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 9);
                end else begin
                    hold[i]--;
                end
            end
            sw_raw = NS'($urandom);
            if ($urandom_range(0, 15) == 0) irq_mask = NB'($urandom);
            irq_clear = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
            led_we = ($urandom_range(0, 3) == 0);
            led_wdata = NL'($urandom);
            reset = ($urandom_range(0, 399) == 0);
            step(1);
        end
        reset = 1'b0;
        step(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
